// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the 16-bit SPI master.
//   spi_state_e      : frame sequencer states
//   SPI_WORD_W       : bits per frame
//   SPI_MIN_*        : smallest legal values of the master's timing parameters
//   spi_max4()       : widest of four counts, sizes the shared phase timer
package spi_pkg;

   localparam int SPI_WORD_W       = 16;

   // The slave needs a 2-flop sync plus edge detect per sck level, and a
   // couple of ssel-high cycles to clear its bit counter between frames.
   localparam int SPI_MIN_CLK_DIV  = 4;
   localparam int SPI_MIN_CS_SETUP = 2;
   localparam int SPI_MIN_CS_HOLD  = 1;
   localparam int SPI_MIN_CS_IDLE  = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      LO,
      HI,
      HOLD,
      GAP
   } spi_state_e;

   function automatic int spi_max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter that times every sequencer phase.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with load_val (phase length - 1)
//   load_val   : value to load
//   expired    : high on the last cycle of the current phase
module spi_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   // Counter parks at zero outside a phase; the sequencer only looks at
   // expired in states that loaded it.
   assign expired = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0, MSB-first, 16-bit-per-frame SPI master.
//   clk, rst_n         : clock, async active-low reset
//   start, dataToSend  : frame request and word, captured when busy=0
//   busy               : frame in progress, including the inter-frame gap
//   done, receivedData : one-cycle pulse; reply word valid from that cycle
//   sck, mosi, ssel    : bus outputs (sck idle low, ssel active low)
//   miso               : bus input, sampled on the last cycle of each sck-high phase
// Optional feature: define SPI_MASTER_BURST_EN to chain words back-to-back
// with ssel held low when start is high on the last high phase of bit 15.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [SPI_WORD_W-1:0] dataToSend,
   output logic                  busy,
   output logic                  done,
   output logic [SPI_WORD_W-1:0] receivedData,
   output logic                  sck,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  ssel
);

   if (CLK_DIV < SPI_MIN_CLK_DIV) begin : g_bad_clk_div
      $error("spi_master: CLK_DIV below minimum");
   end
   if (CS_SETUP < SPI_MIN_CS_SETUP) begin : g_bad_cs_setup
      $error("spi_master: CS_SETUP below minimum");
   end
   if (CS_HOLD < SPI_MIN_CS_HOLD) begin : g_bad_cs_hold
      $error("spi_master: CS_HOLD below minimum");
   end
   if (CS_IDLE < SPI_MIN_CS_IDLE) begin : g_bad_cs_idle
      $error("spi_master: CS_IDLE below minimum");
   end

   localparam int TMR_W = $clog2(spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE));
   localparam logic [TMR_W-1:0] LD_DIV   = TMR_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] LD_SETUP = TMR_W'(CS_SETUP - 1);
   localparam logic [TMR_W-1:0] LD_HOLD  = TMR_W'(CS_HOLD - 1);
   localparam logic [TMR_W-1:0] LD_IDLE  = TMR_W'(CS_IDLE - 1);

   spi_state_e            state_q, state_d;
   logic [SPI_WORD_W-1:0] tx_q, tx_d;
   logic [SPI_WORD_W-1:0] rx_q, rx_d;
   logic [SPI_WORD_W-1:0] rdata_q, rdata_d;
   logic [3:0]            bit_q, bit_d;
   logic                  mosi_q, mosi_d;
   logic                  sck_q, sck_d;
   logic                  ssel_q, ssel_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic                  tmr_load;
   logic [TMR_W-1:0]      tmr_val;
   logic                  tmr_exp;

   spi_phase_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_exp)
   );

   always_comb begin
      state_d  = state_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      rdata_d  = rdata_q;
      bit_d    = bit_q;
      mosi_d   = mosi_q;
      done_d   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = LD_DIV;

      case (state_q)
         IDLE: begin
            if (start) begin
               tx_d     = dataToSend;
               bit_d    = 4'd0;
               mosi_d   = dataToSend[SPI_WORD_W-1];
               state_d  = SETUP;
               tmr_load = 1'b1;
               tmr_val  = LD_SETUP;
            end
         end
         SETUP: begin
            if (tmr_exp) begin
               state_d  = HI;
               tmr_load = 1'b1;
               tmr_val  = LD_DIV;
            end
         end
         HI: begin
            if (tmr_exp) begin
               // Latest point before the falling edge: gives miso the whole
               // high phase to settle after the slave's synchronizer.
               rx_d     = {rx_q[SPI_WORD_W-2:0], miso};
               bit_d    = bit_q + 4'd1;
               tmr_load = 1'b1;
               if (bit_q != 4'd15) begin
                  state_d = LO;
                  tx_d    = {tx_q[SPI_WORD_W-2:0], 1'b0};
                  mosi_d  = tx_q[SPI_WORD_W-2];
                  tmr_val = LD_DIV;
               end else begin
`ifdef SPI_MASTER_BURST_EN
                  if (start) begin
                     // Chain the next word: its MSB goes out on this falling
                     // edge, exactly like any mid-word bit.
                     state_d = LO;
                     tx_d    = dataToSend;
                     mosi_d  = dataToSend[SPI_WORD_W-1];
                     rdata_d = rx_d;
                     done_d  = 1'b1;
                     tmr_val = LD_DIV;
                  end else begin
                     state_d = HOLD;
                     tmr_val = LD_HOLD;
                  end
`else
                  state_d = HOLD;
                  tmr_val = LD_HOLD;
`endif
               end
            end
         end
         LO: begin
            if (tmr_exp) begin
               state_d  = HI;
               tmr_load = 1'b1;
               tmr_val  = LD_DIV;
            end
         end
         HOLD: begin
            if (tmr_exp) begin
               state_d  = GAP;
               rdata_d  = rx_q;
               done_d   = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = LD_IDLE;
            end
         end
         GAP: begin
            if (tmr_exp) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Bus pins are registered from the next state so they line up with it.
      busy_d = (state_d != IDLE);
      ssel_d = !(state_d inside {SETUP, LO, HI, HOLD});
      sck_d  = (state_d == HI);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tx_q    <= '0;
         rx_q    <= '0;
         rdata_q <= '0;
         bit_q   <= 4'd0;
         mosi_q  <= 1'b0;
         sck_q   <= 1'b0;
         ssel_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         bit_q   <= bit_d;
         mosi_q  <= mosi_d;
         sck_q   <= sck_d;
         ssel_q  <= ssel_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign receivedData = rdata_q;
   assign sck          = sck_q;
   assign mosi         = mosi_q;
   assign ssel         = ssel_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master with an ideal mode-0
// slave model on the bus. Expected words come from the slave's send queue
// and the master's requested words; expected timing from the frame formula.
module tb_spi_master;

   localparam int CLK_DIV  = 4;
   localparam int CS_SETUP = 2;
   localparam int CS_HOLD  = 2;
   localparam int CS_IDLE  = 2;
   localparam int EXP_DONE = 1 + CS_SETUP + 32*CLK_DIV - CLK_DIV + CS_HOLD;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] dataToSend = 16'h0;
   logic        busy, done, sck, mosi, ssel;
   logic        miso = 1'b0;
   logic [15:0] receivedData;

   spi_master #(
      .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .dataToSend(dataToSend),
      .busy(busy), .done(done), .receivedData(receivedData),
      .sck(sck), .mosi(mosi), .miso(miso), .ssel(ssel)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Ideal slave plus bus monitors, all sampled on the falling clk edge.
   logic [15:0] sq[$];          // words the slave will send
   logic [15:0] slave_got[$];   // words the slave received
   logic [15:0] done_words[$];  // master receivedData at each done
   int          done_cyc[$];
   logic [15:0] scur = 16'h0;
   logic [15:0] srx = 16'h0;
   int          bi = 0;
   int          rise_cnt = 0;
   int          done_cnt = 0;
   int          last_done_cyc = 0;
   bit          burst_mode = 1'b0;
   logic        prev_sck = 1'b0;
   logic        prev_ssel = 1'b1;

   always @(negedge clk) begin
      if (prev_ssel && !ssel) begin
         scur = (sq.size() > 0) ? sq.pop_front() : 16'h0;
         bi   = 0;
         miso = scur[15];
      end
      if (!ssel && !prev_sck && sck) begin
         srx = {srx[14:0], mosi};
         rise_cnt++;
         bi++;
         if (bi == 16) begin
            slave_got.push_back(srx);
            bi = 0;
            scur = (burst_mode && sq.size() > 0) ? sq.pop_front() : 16'h0;
         end
      end
      if (!ssel && prev_sck && !sck) miso = scur[15-bi];
      if (done) begin
         done_cnt++;
         last_done_cyc = cyc;
         done_words.push_back(receivedData);
         done_cyc.push_back(cyc);
      end
      prev_sck  = sck;
      prev_ssel = ssel;
   end

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 1000) begin tick(); n++; end
      if (busy) chk({tag, "_idle_timeout"}, 32'(busy), 32'd0);
   endtask

   task automatic run_frame(input logic [15:0] mw, input logic [15:0] sw, input string tag);
      int c0, d0, n;
      wait_idle(tag);
      sq.push_back(sw);
      rise_cnt   = 0;
      d0         = done_cnt;
      c0         = cyc;
      start      = 1'b1;
      dataToSend = mw;
      tick();
      start      = 1'b0;
      dataToSend = 16'($urandom);
      n = 0;
      while (done_cnt == d0 && n < 400) begin tick(); n++; end
      chk({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
      chk({tag, "_done_cycle"}, 32'(last_done_cyc - c0), 32'(EXP_DONE));
      chk({tag, "_mst_rx"}, 32'(receivedData), 32'(sw));
      chk({tag, "_sck_rises"}, 32'(rise_cnt), 32'd16);
      if (slave_got.size() == 0) chk({tag, "_slv_empty"}, 32'd0, 32'd1);
      else chk({tag, "_slv_rx"}, 32'(slave_got.pop_front()), 32'(mw));
      wait_idle(tag);
      chk({tag, "_busy_fall"}, 32'(cyc - last_done_cyc), 32'(CS_IDLE));
      chk({tag, "_one_done"}, 32'(done_cnt - d0), 32'd1);
   endtask

   initial begin
      logic [15:0] mw, sw;
      int n, hi, d0;

      // Reset state
      tick(); tick();
      chk("rst_ssel", 32'(ssel), 32'd1);
      chk("rst_sck",  32'(sck),  32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_rx",   32'(receivedData), 32'd0);
      rst_n = 1'b1;
      tick(); tick();

      run_frame(16'hA5C3, 16'h3C5A, "single");
      run_frame(16'hFFFF, 16'h0000, "ones_out");
      run_frame(16'h0000, 16'hFFFF, "zeros_out");
      for (int i = 0; i < 5; i++) begin
         mw = 16'($urandom);
         sw = 16'($urandom);
         run_frame(mw, sw, $sformatf("rand%0d", i));
      end

`ifndef SPI_MASTER_BURST_EN
      // start held through a frame: one frame, then a fresh one after the gap
      sq.push_back(16'h1111);
      sq.push_back(16'h2222);
      rise_cnt = 0;
      d0 = done_cnt;
      start = 1'b1;
      dataToSend = 16'h8001;
      n = 0;
      while (done_cnt == d0 && n < 400) begin tick(); n++; end
      chk("hold_first_done", 32'(done_cnt - d0), 32'd1);
      hi = 0;
      while (ssel && hi < 50) begin hi++; tick(); end
      start = 1'b0;
      chk("hold_gap_len", 32'(hi), 32'(CS_IDLE + 1));
      chk("hold_rises", 32'(rise_cnt), 32'd16);
      chk("hold_done_cnt", 32'(done_cnt - d0), 32'd1);
      n = 0;
      while (done_cnt == d0 + 1 && n < 400) begin tick(); n++; end
      chk("hold_second_done", 32'(done_cnt - d0), 32'd2);
      chk("hold_rx2", 32'(receivedData), 32'h2222);
      chk("hold_slv_cnt", 32'(slave_got.size()), 32'd2);
      while (slave_got.size() > 0) chk("hold_slv_rx", 32'(slave_got.pop_front()), 32'h8001);
      wait_idle("hold");
`endif

      // Reset during bit 7
      wait_idle("rst_mid");
      sq.push_back(16'hDEAD);
      rise_cnt = 0;
      d0 = done_cnt;
      start = 1'b1;
      dataToSend = 16'h5555;
      tick();
      start = 1'b0;
      n = 0;
      while (rise_cnt < 8 && n < 400) begin tick(); n++; end
      chk("rstmid_reached_bit7", 32'(rise_cnt), 32'd8);
      rst_n = 1'b0;
      #1;
      chk("rstmid_ssel", 32'(ssel), 32'd1);
      chk("rstmid_sck",  32'(sck),  32'd0);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_done", 32'(done), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rstmid_no_done", 32'(done_cnt - d0), 32'd0);
      chk("rstmid_rx_clr", 32'(receivedData), 32'd0);
      chk("rstmid_no_word", 32'(slave_got.size()), 32'd0);
      run_frame(16'h1234, 16'h4321, "after_rst");

`ifdef SPI_MASTER_BURST_EN
      // Three chained words; start dropped after the second burst done
      wait_idle("burst");
      burst_mode = 1'b1;
      done_words.delete();
      done_cyc.delete();
      sq.push_back(16'hBEEF);
      sq.push_back(16'h0F0F);
      sq.push_back(16'hC001);
      d0 = done_cnt;
      n = cyc;
      start = 1'b1;
      dataToSend = 16'h1234;
      tick();
      dataToSend = 16'hFEDC;
      hi = 0;
      for (int k = 0; k < 2000 && done_cnt < d0 + 3; k++) begin
         tick();
         if (done_cnt == d0 + 1) dataToSend = 16'h5A5A;
         if (done_cnt == d0 + 2) start = 1'b0;
         if (ssel && done_cnt < d0 + 3) hi++;
      end
      start = 1'b0;
      chk("burst_dones", 32'(done_cnt - d0), 32'd3);
      chk("burst_ssel_low", 32'(hi), 32'd0);
      if (done_cyc.size() == 3) begin
         chk("burst_first", 32'(done_cyc[0] - n), 32'(1 + CS_SETUP + 31*CLK_DIV));
         chk("burst_gap1", 32'(done_cyc[1] - done_cyc[0]), 32'(32*CLK_DIV));
         chk("burst_gap2", 32'(done_cyc[2] - done_cyc[1]), 32'(32*CLK_DIV + CS_HOLD));
         chk("burst_rx0", 32'(done_words[0]), 32'hBEEF);
         chk("burst_rx1", 32'(done_words[1]), 32'h0F0F);
         chk("burst_rx2", 32'(done_words[2]), 32'hC001);
      end
      chk("burst_slv_cnt", 32'(slave_got.size()), 32'd3);
      if (slave_got.size() == 3) begin
         chk("burst_slv0", 32'(slave_got[0]), 32'h1234);
         chk("burst_slv1", 32'(slave_got[1]), 32'hFEDC);
         chk("burst_slv2", 32'(slave_got[2]), 32'h5A5A);
      end
      wait_idle("burst_end");
      burst_mode = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
